vjtag_dr_endpoint: RTL

- User-side endpoint for the 2-bit-IR virtual JTAG hub. It consumes the hub's tck, tdi, ir_in and virtual_state_* strobes, and drives tdo and ir_out back to the hub.
- Implements four instructions: BYPASS, WRITE (host to fabric), READ (fabric to host) and STATUS.
- A small RX FIFO and a single-entry TX holding register are exposed to fabric logic in the same tck domain.

---
 rtl/vjtag_dr_endpoint_pkg.sv | 18 +
 rtl/vjtag_dr_endpoint_if.sv | 33 +++
 rtl/vjtag_dr_endpoint_fifo.sv | 59 +++++
 rtl/vjtag_dr_endpoint.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vjtag_dr_endpoint_pkg.sv
// Shared definitions for the virtual JTAG DR endpoint: IR codes and STATUS layout.
package vjtag_ep_pkg;

    typedef enum logic [1:0] {
        IR_BYPASS = 2'b00,
        IR_WRITE  = 2'b01,
        IR_READ   = 2'b10,
        IR_STATUS = 2'b11
    } ir_code_e;

    // STATUS capture word layout, LSB first
    localparam int unsigned ST_TX_UNF     = 0;
    localparam int unsigned ST_RX_OVF     = 1;
    localparam int unsigned ST_TX_FULL    = 2;
    localparam int unsigned ST_RX_CNT_LSB = 3;
    localparam int unsigned ST_RX_CNT_W   = 5;

endpackage

// File: rtl/vjtag_dr_endpoint_if.sv
// Hub-facing scan signals plus fabric-facing RX/TX handshakes of the DR endpoint.
interface vjtag_dr_endpoint_if #(
    parameter int unsigned DATA_W = 8
);
    logic              tdi;
    logic              tdo;
    logic [1:0]        ir_in;
    logic [1:0]        ir_out;
    logic              virtual_state_cdr;
    logic              virtual_state_sdr;
    logic              virtual_state_udr;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    // Hub and fabric side together drive the endpoint's inputs
    modport master (
        output tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
        output rx_ready, tx_data, tx_valid,
        input  tdo, ir_out, rx_data, rx_valid, tx_ready
    );

    // The endpoint itself
    modport slave (
        input  tdi, ir_in, virtual_state_cdr, virtual_state_sdr, virtual_state_udr,
        input  rx_ready, tx_data, tx_valid,
        output tdo, ir_out, rx_data, rx_valid, tx_ready
    );

endinterface

// File: rtl/vjtag_dr_endpoint_fifo.sv
// Single-clock FIFO; a push while full succeeds only when a pop frees a slot in the same cycle.
module vjtag_sync_fifo #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array, no reset needed since reads are masked while empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vjtag_dr_endpoint.sv
// Virtual JTAG DR endpoint: BYPASS/WRITE/READ/STATUS over a shared DR, RX FIFO and TX holding register.
module vjtag_dr_endpoint
    import vjtag_ep_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RX_DEPTH = 4
) (
    input logic               tck,
    input logic               reset,
    vjtag_dr_endpoint_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(RX_DEPTH + 1);

    ir_code_e          ir;
    logic              cdr;
    logic              udr;
    logic              sdr;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] tx_hold;
    logic [DATA_W-1:0] status_word;
    logic              byp;
    logic              tx_full;
    logic              rx_ovf;
    logic              tx_unf;
    logic              rx_push;
    logic              rx_full;
    logic              rx_empty;
    logic [CNT_W-1:0]  rx_count;

    assign ir  = ir_code_e'(bus.ir_in);
    // Strobe priority CDR > UDR > SDR
    assign cdr = bus.virtual_state_cdr;
    assign udr = bus.virtual_state_udr && !cdr;
    assign sdr = bus.virtual_state_sdr && !cdr && !udr;

    assign rx_push = udr && (ir == IR_WRITE);

    vjtag_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk       (tck),
        .rst       (reset),
        .push      (rx_push),
        .push_data (sr),
        .pop       (bus.rx_ready),
        .pop_data  (bus.rx_data),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    assign bus.rx_valid = !rx_empty;
    assign bus.tx_ready = !tx_full;
    assign bus.tdo      = (ir == IR_BYPASS) ? byp : sr[0];

    // Assemble the STATUS capture word from live flags and FIFO occupancy
    always_comb begin
        status_word             = '0;
        status_word[ST_TX_UNF]  = tx_unf;
        status_word[ST_RX_OVF]  = rx_ovf;
        status_word[ST_TX_FULL] = tx_full;
        status_word[ST_RX_CNT_LSB +: ST_RX_CNT_W] = ST_RX_CNT_W'(rx_count);
    end

    // Scan chain, TX holding register and sticky error flags
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            sr      <= '0;
            byp     <= 1'b0;
            tx_hold <= '0;
            tx_full <= 1'b0;
            rx_ovf  <= 1'b0;
            tx_unf  <= 1'b0;
        end else begin
            // A fabric load needs tx_full=0 and a READ capture needs tx_full=1, so they never collide
            if (bus.tx_valid && !tx_full) begin
                tx_hold <= bus.tx_data;
                tx_full <= 1'b1;
            end
            if (cdr) begin
                case (ir)
                    IR_BYPASS: byp <= 1'b0;
                    IR_WRITE:  ;
                    IR_READ: begin
                        if (tx_full) begin
                            sr      <= tx_hold;
                            tx_full <= 1'b0;
                        end else begin
                            sr     <= '0;
                            tx_unf <= 1'b1;
                        end
                    end
                    IR_STATUS: sr <= status_word;
                    default:   ;
                endcase
            end else if (udr) begin
                // A same-cycle pop frees a slot, so a push into a full FIFO is not an overflow then
                if ((ir == IR_WRITE) && rx_full && !bus.rx_ready) begin
                    rx_ovf <= 1'b1;
                end
                if ((ir == IR_STATUS) && sr[0]) begin
                    rx_ovf <= 1'b0;
                    tx_unf <= 1'b0;
                end
            end else if (sdr) begin
                if (ir == IR_BYPASS) begin
                    byp <= bus.tdi;
                end else begin
                    sr <= {bus.tdi, sr[DATA_W-1:1]};
                end
            end
        end
    end

    // Registered IR capture value so the host sees it at Capture-IR
    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            bus.ir_out <= 2'b00;
        end else begin
            bus.ir_out <= {!rx_empty, tx_full};
        end
    end

endmodule
